// File: rtl/weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// weight_read_sequencer
//
// Streams one neuron's worth of weights out of a registered-read weight memory
// and pairs each weight with the input activation that requested it. Every
// accepted activation issues one memory read. One cycle later, the activation
// (delayed to match the memory) and the returned weight come out together as a
// pair. The output path has no backpressure.
//
// Optional feature (macro WSEQ_BIAS_EN):
//   When defined, after the last weight the sequencer reads the bias word at
//   address NUM_WEIGHT. It then emits one extra pair (x = 1, w = bias) with
//   out_bias set. When undefined, out_bias is tied low and no bias read occurs.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a pass (honoured only in IDLE)
//   busy, done             pass in progress / one-cycle end-of-pass pulse
//   in_valid, in_data      input activation stream
//   in_ready               high only while the sequencer is consuming inputs
//   mem_ren, mem_radd      weight memory read request
//   mem_wout               weight memory data (valid one cycle after mem_ren)
//   out_valid, out_x,      activation/weight pair
//   out_w, out_last,       final pair of the pass
//   out_bias               pair carries the bias word
// -----------------------------------------------------------------------------
module weight_read_sequencer #(
    parameter int NUM_WEIGHT    = 784,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     mem_ren,
    output logic [ADDRESS_WIDTH-1:0] mem_radd,
    input  logic [DATA_WIDTH-1:0]    mem_wout,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_x,
    output logic [DATA_WIDTH-1:0]    out_w,
    output logic                     out_last,
    output logic                     out_bias
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_WEIGHT - 1);
`ifdef WSEQ_BIAS_EN
    localparam logic [ADDRESS_WIDTH-1:0] BIAS_ADDR = ADDRESS_WIDTH'(NUM_WEIGHT);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        BIAS  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] cnt_reg;       // next weight address to read
    logic [ADDRESS_WIDTH-1:0] radd_reg;      // last address driven, held between reads
    logic [DATA_WIDTH-1:0]    x_reg;         // activation delayed to line up with mem_wout
    logic                     pair_reg;      // a read was issued last cycle
    logic                     accept;
    logic                     bias_rd;       // bias read cycle (always 0 without the feature)

    assign accept = in_valid && in_ready;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = RUN;
            RUN: begin
                if (accept && (cnt_reg == LAST_ADDR)) begin
`ifdef WSEQ_BIAS_EN
                    state_next = BIAS;
`else
                    state_next = DRAIN;
`endif
                end
            end
            BIAS:  state_next = DRAIN;
            DRAIN: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
        in_ready = (state_reg == RUN);
`ifdef WSEQ_BIAS_EN
        bias_rd  = (state_reg == BIAS);
`else
        bias_rd  = 1'b0;
`endif
        mem_ren  = accept || bias_rd;
        mem_radd = radd_reg;
        if (accept) begin
            mem_radd = cnt_reg;
        end
`ifdef WSEQ_BIAS_EN
        if (bias_rd) begin
            mem_radd = BIAS_ADDR;
        end
`endif
        out_valid = pair_reg;
        out_x     = x_reg;
        // Weight is only meaningful when a read was issued last cycle; gate it
        // so the output is 0 after reset and between pairs.
        out_w     = pair_reg ? mem_wout : '0;
        // The final pair always lands in DRAIN: the last weight read normally,
        // or the bias word when the bias feature is enabled.
        out_last  = pair_reg && (state_reg == DRAIN);
`ifdef WSEQ_BIAS_EN
        out_bias  = pair_reg && (state_reg == DRAIN);
`else
        out_bias  = 1'b0;
`endif
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            radd_reg <= '0;
            x_reg    <= '0;
            pair_reg <= 1'b0;
        end else begin
            pair_reg <= mem_ren;
            if (mem_ren) begin
                radd_reg <= mem_radd;
            end
            if ((state_reg == IDLE) && start) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (accept) begin
                x_reg <= in_data;
            end else if (bias_rd) begin
                // Bias is multiplied by a literal integer 1.
                x_reg <= DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weight_read_sequencer
//
// Directed bench for weight_read_sequencer. u_dut runs with NUM_WEIGHT=4 and
// u_dut1 runs with NUM_WEIGHT=1. Each has a registered-read weight memory
// holding w[i] = i+10 and the bias word 99 at address NUM_WEIGHT. Inputs are
// driven 1 time unit after the rising edge. Outputs are checked 3 time units
// later, which keeps sampling away from both clock edges. Expected values
// follow WSEQ_BIAS_EN when the bench is compiled with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_weight_read_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [DW-1:0] in_data, mem_wout, out_x, out_w;
    logic          busy, done, in_ready, mem_ren, out_valid, out_last, out_bias;
    logic [3:0]    mem_radd;

    logic          start1, in_valid1;
    logic [DW-1:0] in_data1, mem_wout1, out_x1, out_w1;
    logic          busy1, done1, in_ready1, mem_ren1, out_valid1, out_last1, out_bias1;
    logic [0:0]    mem_radd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_read_sequencer #(.NUM_WEIGHT(4), .DATA_WIDTH(DW), .ADDRESS_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_wout(mem_wout),
        .out_valid(out_valid), .out_x(out_x), .out_w(out_w),
        .out_last(out_last), .out_bias(out_bias)
    );

    weight_read_sequencer #(.NUM_WEIGHT(1), .DATA_WIDTH(DW), .ADDRESS_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_wout(mem_wout1),
        .out_valid(out_valid1), .out_x(out_x1), .out_w(out_w1),
        .out_last(out_last1), .out_bias(out_bias1)
    );

    // Weight memories: registered read, w[i] = i+10, bias word 99.
    always_ff @(posedge clk) begin
        if (mem_ren)  mem_wout  <= (mem_radd == 4'd4) ? DW'(99) : DW'(mem_radd) + DW'(10);
        if (mem_ren1) mem_wout1 <= (mem_radd1 == 1'b1) ? DW'(99) : DW'(10);
    end

    // One line per output pair.
    always @(negedge clk) begin
        if (out_valid)  $display("pair  dut  x=%0d w=%0d last=%0b bias=%0b", out_x, out_w, out_last, out_bias);
        if (out_valid1) $display("pair  dut1 x=%0d w=%0d last=%0b bias=%0b", out_x1, out_w1, out_last1, out_bias1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full pass on u_dut with inputs 1..4. If stall_len > 0, in_valid drops
    // for stall_len cycles before input stall_at+1. If start_busy is set,
    // start is held high through every busy cycle, DONE included.
    task automatic run_pass(input int stall_at, input int stall_len, input logic start_busy);
        logic prev_acc;
        prev_acc = 1'b0;
        tick; start = 1'b1; in_valid = 1'b0; #3;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_ready", 32'(in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    tick; start = start_busy; in_valid = 1'b0; in_data = 16'hdead; #3;
                    chk("stall_ready", 32'(in_ready), 1);
                    chk("stall_ren", 32'(mem_ren), 0);
                    chk("stall_radd", 32'(mem_radd), 32'(k - 1));
                    chk("stall_valid", 32'(out_valid), 32'(prev_acc));
                    prev_acc = 1'b0;
                end
            end
            tick; start = start_busy; in_valid = 1'b1; in_data = DW'(k + 1); #3;
            chk("run_busy", 32'(busy), 1);
            chk("run_ready", 32'(in_ready), 1);
            chk("run_ren", 32'(mem_ren), 1);
            chk("run_radd", 32'(mem_radd), 32'(k));
            chk("run_valid", 32'(out_valid), 32'(prev_acc));
            if (prev_acc) begin
                chk("run_x", 32'(out_x), 32'(k));
                chk("run_w", 32'(out_w), 32'(k + 9));
                chk("run_last", 32'(out_last), 0);
            end
            prev_acc = 1'b1;
        end
        // in_valid stays high after the final accept; nothing more may be taken.
        tick; start = start_busy; in_data = 16'h55; #3;
        chk("post_ready", 32'(in_ready), 0);
        chk("post_x", 32'(out_x), 4);
        chk("post_w", 32'(out_w), 13);
        chk("post_valid", 32'(out_valid), 1);
`ifdef WSEQ_BIAS_EN
        chk("bias_ren", 32'(mem_ren), 1);
        chk("bias_radd", 32'(mem_radd), 4);
        chk("bias_last0", 32'(out_last), 0);
        chk("bias_pbias", 32'(out_bias), 0);
        tick; start = start_busy; #3;
        chk("bias_valid", 32'(out_valid), 1);
        chk("bias_x", 32'(out_x), 1);
        chk("bias_w", 32'(out_w), 99);
        chk("bias_flag", 32'(out_bias), 1);
`else
        chk("drain_bias", 32'(out_bias), 0);
`endif
        chk("drain_last", 32'(out_last), 1);
        chk("drain_ren", 32'(mem_ren), 0);
        chk("drain_done", 32'(done), 0);
        tick; start = start_busy; in_valid = 1'b0; #3;
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_valid", 32'(out_valid), 0);
        tick; start = 1'b0; #3;
        chk("end_done", 32'(done), 0);
        chk("end_busy", 32'(busy), 0);
        // Any start seen while busy or in DONE must not have launched a new pass.
        tick; #3;
        chk("stay_idle", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_ren", 32'(mem_ren), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_bias", 32'(out_bias), 0);
        chk("rst_radd", 32'(mem_radd), 0);
        chk("rst_x", 32'(out_x), 0);
        chk("rst_w", 32'(out_w), 0);

        // Back-to-back pass.
        run_pass(-1, 0, 1'b0);
        // Three-cycle stall between inputs 2 and 3.
        run_pass(2, 3, 1'b0);
        // start held high while busy and during DONE.
        run_pass(-1, 0, 1'b1);

        // Reset after the 2nd accept.
        tick; start = 1'b1; #3;
        tick; start = 1'b0; in_valid = 1'b1; in_data = 16'd1; #3;
        tick; in_data = 16'd2; #3;
        chk("pre_rst_radd", 32'(mem_radd), 1);
        tick; rst = 1'b1; in_data = 16'd3; #3;
        tick; rst = 1'b0; in_valid = 1'b0; #3;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_radd", 32'(mem_radd), 0);
        chk("mid_rst_x", 32'(out_x), 0);
        // rst wins over start.
        tick; rst = 1'b1; start = 1'b1; #3;
        tick; rst = 1'b0; start = 1'b0; #3;
        chk("rst_over_start", 32'(busy), 0);
        // A full pass restarts at address 0.
        run_pass(-1, 0, 1'b0);

        // NUM_WEIGHT = 1.
        tick; start1 = 1'b1; #3;
        tick; start1 = 1'b0; in_valid1 = 1'b1; in_data1 = 16'd7; #3;
        chk("n1_ready", 32'(in_ready1), 1);
        chk("n1_ren", 32'(mem_ren1), 1);
        chk("n1_radd", 32'(mem_radd1), 0);
        tick; #3;
        chk("n1_post_ready", 32'(in_ready1), 0);
        chk("n1_valid", 32'(out_valid1), 1);
        chk("n1_x", 32'(out_x1), 7);
        chk("n1_w", 32'(out_w1), 10);
`ifdef WSEQ_BIAS_EN
        chk("n1_last0", 32'(out_last1), 0);
        chk("n1_bias_radd", 32'(mem_radd1), 1);
        tick; in_valid1 = 1'b0; #3;
        chk("n1_bias_x", 32'(out_x1), 1);
        chk("n1_bias_w", 32'(out_w1), 99);
        chk("n1_bias_flag", 32'(out_bias1), 1);
`endif
        chk("n1_last", 32'(out_last1), 1);
        chk("n1_done_early", 32'(done1), 0);
        tick; in_valid1 = 1'b0; #3;
        chk("n1_done", 32'(done1), 1);
        chk("n1_done_valid", 32'(out_valid1), 0);
        tick; #3;
        chk("n1_idle", 32'(busy1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_read_sequencer.md
WEIGHT_READ_SEQUENCER -- requirements
Module: weight_read_sequencer

Interface
REQ-001 SHALL have parameter NUM_WEIGHT, default 784, meaning the number of weights per neuron (must be >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the weight and input word width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 10, meaning the memory address width (2**ADDRESS_WIDTH >= NUM_WEIGHT+1).
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-005 Ports, in this order:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: begin one neuron pass.
- busy, output, 1: a pass is in progress.
- done, output, 1: one-cycle pulse at the end of a pass.
- in_valid, input, 1: input activation valid.
- in_data, input, DATA_WIDTH: input activation.
- in_ready, output, 1: sequencer accepts in_data.
- mem_ren, output, 1: read enable to the weight memory.
- mem_radd, output, ADDRESS_WIDTH: read address to the weight memory.
- mem_wout, input, DATA_WIDTH: weight memory data, registered one cycle after mem_ren.
- out_valid, output, 1: activation/weight pair valid.
- out_x, output, DATA_WIDTH: activation aligned to out_w.
- out_w, output, DATA_WIDTH: weight.
- out_last, output, 1: final pair of the pass.
- out_bias, output, 1: the current pair carries the bias (WSEQ_BIAS_EN only, else tied 0).

Function
REQ-006 FSM states SHALL be IDLE, RUN, BIAS, DRAIN and DONE. BIAS SHALL be reachable only when WSEQ_BIAS_EN is defined.
REQ-007 IDLE->RUN SHALL occur on start; the address counter SHALL clear to 0 at that transition.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 in_ready SHALL equal 1 only in RUN.
REQ-010 Accept condition: in_valid & in_ready.
- On accept: mem_ren=1 and mem_radd=counter, both combinational in that cycle.
- On accept: in_data SHALL be registered into an x-delay register, and the counter SHALL increment.
REQ-011 When not accepting, mem_ren SHALL be 0 and mem_radd SHALL hold its last value.
REQ-012 Exactly one cycle after an accept:
- out_valid SHALL be 1, out_x SHALL be the delayed in_data, and out_w SHALL equal mem_wout.
- In all other cycles out_valid SHALL be 0.
REQ-013 Fixed latency: accept-to-out_valid SHALL be exactly 1 cycle, and there SHALL be no backpressure on the output.
REQ-014 Leaving RUN: the accept at counter NUM_WEIGHT-1 SHALL move the FSM to DRAIN (BIAS if WSEQ_BIAS_EN).
REQ-015 DRAIN SHALL last one cycle and emit the final pair with out_last=1, then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-017 busy SHALL be 1 in RUN, BIAS, DRAIN and DONE, and 0 in IDLE.
REQ-018 Input stalls (in_valid=0 in RUN) SHALL hold the counter and produce no out_valid; a pass of any stall length SHALL complete correctly.
REQ-019 The counter SHALL never exceed NUM_WEIGHT; in_ready SHALL be 0 on the cycle after the final accept.
REQ-020 If start coincides with done (the DONE cycle), start SHALL be ignored; a new pass requires start while in IDLE.
REQ-021 NUM_WEIGHT=1 SHALL work: RUN accepts once, then DRAIN emits out_last.

Reset
REQ-022 On rst=1 at a clock edge, regardless of state:
- the FSM SHALL go to IDLE and the counter SHALL go to 0;
- busy, done, in_ready, mem_ren, out_valid, out_last and out_bias SHALL be 0;
- mem_radd, out_x and out_w SHALL be 0.
REQ-023 Reset mid-pass SHALL discard any in-flight pair; no out_valid SHALL appear in the cycle after reset.
REQ-024 rst SHALL take priority over start.

Configuration
REQ-025 Macro WSEQ_BIAS_EN.
- When defined: after the accept at NUM_WEIGHT-1, the FSM SHALL enter BIAS for one cycle.
- In BIAS: mem_ren=1, mem_radd=NUM_WEIGHT, in_ready=0, and no input SHALL be consumed.
- The cycle after BIAS SHALL be DRAIN: out_valid=1, out_w=mem_wout, out_x=1 (fixed-point one is not implied; literal integer 1), out_bias=1, out_last=1.
- In this mode the preceding weight pair SHALL carry out_last=0, and the pass SHALL have NUM_WEIGHT+1 output pairs.
REQ-026 When WSEQ_BIAS_EN is undefined: there SHALL be no BIAS state, out_bias SHALL be constant 0, and the pass SHALL have NUM_WEIGHT output pairs.

Verification (NUM_WEIGHT=4, memory contents w[i]=i+10, bias word at address 4 = 99)
REQ-027 Back-to-back inputs 1,2,3,4 after start -> out pairs (1,10),(2,11),(3,12),(4,13); out_last on the 4th pair; done one cycle later; mem_radd sequence 0,1,2,3.
REQ-028 in_valid low for 3 cycles between inputs 2 and 3 -> identical pairs; no out_valid during the stall; counter holds at 2.
REQ-029 start asserted while busy, and start asserted in the DONE cycle -> both ignored; exactly one done pulse; the next pass starts only from a start in IDLE.
REQ-030 rst asserted after the 2nd accept -> the next cycle shows busy=0, out_valid=0 and mem_radd=0; a following start restarts at address 0.
REQ-031 WSEQ_BIAS_EN defined, inputs 1..4 -> 4 weight pairs with out_last=0, then mem_radd=4 with in_ready=0, then pair (1,99) with out_bias=1 and out_last=1.
REQ-032 NUM_WEIGHT=1, input 7 -> single pair (7,10) with out_last=1; done two cycles after the accept.
